alarm_bank: RTL and testbench
=============================

# alarm_bank

Parametrised multi-alarm store, editor and comparator for the digital clock. Holds NUM_ALARMS BCD alarm times with per-alarm enable and lets the user browse and edit them while the top-level mode selects alarm setting. Compares each enabled alarm against the running time on every 1 Hz tick and drives a timed ring output. It sits beside the timekeeping counter and feeds the shared 8-digit display mux.

## Interface
- NUM_ALARMS, 3: number of alarm slots (1..8).
- RING_SECONDS, 60: ring duration in ticks (1..255).
- SNOOZE_SECONDS, 300: snooze delay in ticks (used only with ALARM_SNOOZE_EN).

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- active  in  1  block owns buttons/display (top-level alarm mode)
- tick_1hz  in  1  one-cycle pulse per second from the timekeeper
- cur_hour, cur_min, cur_sec  in  8 each  current time, packed BCD
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced one-cycle press pulses
- btn_enter_short, btn_enter_long  in  1 each  one-cycle pulses
- btn_return  in  1  one-cycle pulse
- disp_digits  out  32  nibble k = display digit k+1 (0 = seconds units)
- point  out  8  decimal points, active-low
- which_shine  out  8  one-hot blink mask
- is_shine  out  1  blink enable
- alarm_ring  out  1  ring active
- ring_idx  out  3  slot currently ringing
- alarm_en  out  NUM_ALARMS  enable per slot
- alarm_hms  out  24*NUM_ALARMS  slot i at [24i+23:24i] = {hour, min, sec}

## Operation
- FSM states: SHOW, EDIT. Reset: SHOW, sel=0, cursor=0, all slots 00:00:00, alarm_en=0, alarm_ring=0, ring_idx=0, working copy 0.
- Buttons acted on only when active=1. active=0 in EDIT -> SHOW next cycle, working copy discarded.
- SHOW: left -> sel-1, right -> sel+1, both wrapping over 0..NUM_ALARMS-1; up toggles alarm_en[sel]; btn_enter_long -> copy slot sel to working copy, cursor=0, EDIT.
- EDIT: cursor 0..5 = sec units, sec tens, min units, min tens, hour units, hour tens. left -> cursor+1, right -> cursor-1, wrapping 5<->0.
- up/down wrap per digit: units 0..9, sec/min tens 0..5, hour tens 0..2; hour units limited to 0..3 when hour tens = 2. Raising hour tens to 2 with hour units >3 forces hour units to 3.
- btn_enter_short: commit working copy to slot sel, set alarm_en[sel]=1, -> SHOW. btn_return: discard, -> SHOW.
- Simultaneous pulses in one cycle: priority return > enter > left/right > up/down; only one acted on.
- Display: digits from slot sel (SHOW) or working copy (EDIT); nibbles 2 and 5 = 4'hA (dash). point=8'hFF except point[0]=0 when the displayed slot is enabled. SHOW: is_shine=0, which_shine=0. EDIT: is_shine=1, which_shine bit 0,1,3,4,6,7 for cursor 0..5.
- Compare: on tick_1hz, the lowest-index enabled slot whose {hour,min,sec} equals current time starts ringing (ring_idx set, counter=RING_SECONDS) unless already ringing. Compare is independent of active and state.
- Ring: counter decrements per tick; alarm_ring clears when it reaches 0 or on any button pulse (that pulse is consumed, not acted on by the FSM).

## Timing
- All outputs registered except disp_digits/point/which_shine/is_shine, which are combinational from registered state.
- Button effect visible cycle after the pulse. alarm_ring rises cycle after matching tick_1hz, falls cycle after the final tick or the stop pulse.
- Reset mid-ring or mid-edit: all state returns to reset values next edge.

## Configuration
- ALARM_SNOOZE_EN defined: stop pulse while ringing clears alarm_ring and loads a snooze counter with SNOOZE_SECONDS; on expiry the same ring_idx rings again for RING_SECONDS. A tick match for another slot during snooze cancels the snooze and rings the new slot. Ring timeout (no press) clears snooze. Disabling the snoozed slot cancels it.
- Undefined: no snooze counter; stop pulse simply ends the ring.

## Test plan
- Reset then SHOW: disp_digits=32'h00A00A00, point=8'hFF, alarm_ring=0, alarm_en=0.
- right ×3 with NUM_ALARMS=3 -> sel wraps 0,1,2,0; left from 0 -> 2.
- EDIT slot 1, set 23:59:58, enter_short -> alarm_hms[47:24]=24'h235958, alarm_en[1]=1; hour tens up from 2 -> 0; hour units at tens=2 wraps 3->0.
- Hour units 9 then tens up to 2 -> hour 23; return in EDIT leaves slot unchanged.
- Slot 0=12:00:00 enabled; tick with cur=12:00:00 -> alarm_ring=1, ring_idx=0 next cycle; clears after 60 ticks; btn_up during ring clears it without toggling enable.
- ALARM_SNOOZE_EN, SNOOZE_SECONDS=5: stop during ring -> ring drops, re-asserts cycle after 5th tick with same ring_idx.

Source files
------------

// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm store with browse/edit UI, per-second comparator and timed ring output.
// Latency: button and tick effects are registered (visible 1 cycle later); display outputs are combinational from state.
// Backpressure: none -- inputs are single-cycle pulses; snooze is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_bank #(
    parameter int NUM_ALARMS     = 3,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       active,
    input  logic                       tick_1hz,
    input  logic [7:0]                 cur_hour,
    input  logic [7:0]                 cur_min,
    input  logic [7:0]                 cur_sec,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_enter_short,
    input  logic                       btn_enter_long,
    input  logic                       btn_return,
    output logic [31:0]                disp_digits,
    output logic [7:0]                 point,
    output logic [7:0]                 which_shine,
    output logic                       is_shine,
    output logic                       alarm_ring,
    output logic [2:0]                 ring_idx,
    output logic [NUM_ALARMS-1:0]      alarm_en,
    output logic [24*NUM_ALARMS-1:0]   alarm_hms
);

    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_ALARMS - 1);
    // One counter times both the ring and the snooze interval (they never overlap),
    // so it is sized for whichever is longer.
    localparam int MAX_CNT = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SECONDS);
`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_SECONDS);
`endif

    typedef enum logic {SHOW = 1'b0, EDIT = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sel;
    logic [2:0]         cursor;
    logic [23:0]        slot [NUM_ALARMS];
    logic [23:0]        work;
    logic [23:0]        work_edit;
    logic [23:0]        shown;
    logic [SEL_W-1:0]   ring_idx_q;
    logic [CNT_W-1:0]   cnt_q;
`ifdef ALARM_SNOOZE_EN
    logic               snz_q;
`endif
    logic               match_vld;
    logic [SEL_W-1:0]   match_idx;
    logic [3:0]         dmax;
    logic [3:0]         dcur;
    logic [3:0]         dnew;

    logic any_btn, ring_stop, btn_ok, enter_any, lr_any;
    logic act_ret, act_ent, act_lr, act_ud;

    // A press while ringing only silences the ring; the FSM never sees it.
    assign any_btn   = btn_up | btn_down | btn_left | btn_right |
                       btn_enter_short | btn_enter_long | btn_return;
    assign ring_stop = alarm_ring & any_btn;
    assign btn_ok    = active & ~ring_stop;
    assign enter_any = btn_enter_short | btn_enter_long;
    assign lr_any    = btn_left | btn_right;
    assign act_ret   = btn_ok & btn_return;
    assign act_ent   = btn_ok & ~btn_return & enter_any;
    assign act_lr    = btn_ok & ~btn_return & ~enter_any & lr_any;
    assign act_ud    = btn_ok & ~btn_return & ~enter_any & ~lr_any & (btn_up | btn_down);

    assign ring_idx  = 3'(ring_idx_q);

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_hms
        assign alarm_hms[24*g +: 24] = slot[g];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= SHOW;
        else          state <= state_nxt;
    end

    // Next-state: long enter opens the editor; leaving alarm mode, return or commit closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            SHOW: if (act_ent && btn_enter_long) state_nxt = EDIT;
            EDIT: if (!active || act_ret || (act_ent && btn_enter_short)) state_nxt = SHOW;
            default: state_nxt = SHOW;
        endcase
    end

    // Display outputs: dashes between fields, point 0 flags an enabled slot, blink follows the cursor.
    always_comb begin
        shown       = (state == EDIT) ? work : slot[sel];
        disp_digits = {shown[23:16], 4'hA, shown[15:8], 4'hA, shown[7:0]};
        point       = {7'h7F, ~alarm_en[sel]};
        is_shine    = (state == EDIT);
        which_shine = 8'h00;
        if (state == EDIT) begin
            case (cursor)
                3'd0:    which_shine = 8'h01;
                3'd1:    which_shine = 8'h02;
                3'd2:    which_shine = 8'h08;
                3'd3:    which_shine = 8'h10;
                3'd4:    which_shine = 8'h40;
                default: which_shine = 8'h80;
            endcase
        end
    end

    // Up/down on the digit under the cursor, with per-digit range and the 20-23 hour rule.
    always_comb begin
        case (cursor)
            3'd0, 3'd2: dmax = 4'd9;
            3'd1, 3'd3: dmax = 4'd5;
            3'd4:       dmax = (work[23:20] == 4'd2) ? 4'd3 : 4'd9;
            default:    dmax = 4'd2;
        endcase
        dcur = work[{cursor, 2'b00} +: 4];
        if (btn_up) dnew = (dcur >= dmax) ? 4'd0 : dcur + 4'd1;
        else        dnew = (dcur == 4'd0) ? dmax : dcur - 4'd1;
        work_edit = work;
        work_edit[{cursor, 2'b00} +: 4] = dnew;
        if (work_edit[23:20] == 4'd2 && work_edit[19:16] > 4'd3) work_edit[19:16] = 4'd3;
    end

    // Lowest-index enabled slot equal to the current time.
    always_comb begin
        match_vld = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && slot[i] == {cur_hour, cur_min, cur_sec}) begin
                match_vld = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    // Browse/edit datapath: selection, cursor, working copy, slot storage and enables.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel      <= '0;
            cursor   <= 3'd0;
            work     <= 24'h0;
            alarm_en <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) slot[i] <= 24'h0;
        end else begin
            case (state)
                SHOW: begin
                    if (act_ent && btn_enter_long) begin
                        work   <= slot[sel];
                        cursor <= 3'd0;
                    end else if (act_lr) begin
                        if (btn_left) sel <= (sel == '0) ? LAST_SEL : sel - 1'b1;
                        else          sel <= (sel == LAST_SEL) ? '0 : sel + 1'b1;
                    end else if (act_ud && btn_up) begin
                        alarm_en[sel] <= ~alarm_en[sel];
                    end
                end
                default: begin
                    if (act_ent && btn_enter_short) begin
                        slot[sel]     <= work;
                        alarm_en[sel] <= 1'b1;
                    end else if (act_lr) begin
                        if (btn_left) cursor <= (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
                        else          cursor <= (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
                    end else if (act_ud) begin
                        work <= work_edit;
                    end
                end
            endcase
        end
    end

    // Ring control: start on a tick match, count down per tick, stop on timeout or any press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alarm_ring <= 1'b0;
            ring_idx_q <= '0;
            cnt_q      <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= 1'b0;
`endif
        end else if (ring_stop) begin
            alarm_ring <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= 1'b1;
            cnt_q      <= SNZ_LOAD;
`endif
        end else if (tick_1hz && !alarm_ring && match_vld) begin
            alarm_ring <= 1'b1;
            ring_idx_q <= match_idx;
            cnt_q      <= RING_LOAD;
`ifdef ALARM_SNOOZE_EN
            snz_q      <= 1'b0;
`endif
        end else if (tick_1hz && alarm_ring) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) alarm_ring <= 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snz_q && !alarm_en[ring_idx_q]) begin
            snz_q <= 1'b0;
        end else if (snz_q && tick_1hz) begin
            if (cnt_q <= CNT_W'(1)) begin
                alarm_ring <= 1'b1;
                cnt_q      <= RING_LOAD;
                snz_q      <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: stimulus updates a behavioural model and queues the expected outputs.
// Latency: one expectation per clock, checked on the following falling edge.
// Backpressure: none; a monitor drains the queue every falling edge.
module tb_alarm_bank;
    localparam int N    = 3;
    localparam int RING = 60;
    localparam int SNZ  = 5;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SHORT = 4, B_LONG = 5, B_RET = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic active = 1'b0;
    logic tick_1hz = 1'b0;
    logic [7:0] cur_hour = 8'h0, cur_min = 8'h0, cur_sec = 8'h0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic btn_enter_short = 1'b0, btn_enter_long = 1'b0, btn_return = 1'b0;
    logic [31:0]      disp_digits;
    logic [7:0]       point, which_shine;
    logic             is_shine, alarm_ring;
    logic [2:0]       ring_idx;
    logic [N-1:0]     alarm_en;
    logic [24*N-1:0]  alarm_hms;

    alarm_bank #(.NUM_ALARMS(N), .RING_SECONDS(RING), .SNOOZE_SECONDS(SNZ)) dut (
        .clk(clk), .reset_n(reset_n), .active(active), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_enter_short(btn_enter_short), .btn_enter_long(btn_enter_long), .btn_return(btn_return),
        .disp_digits(disp_digits), .point(point), .which_shine(which_shine), .is_shine(is_shine),
        .alarm_ring(alarm_ring), .ring_idx(ring_idx), .alarm_en(alarm_en), .alarm_hms(alarm_hms)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     disp;
        logic [7:0]      point;
        logic [7:0]      shine;
        logic            is_shine;
        logic            ring;
        logic [2:0]      ridx;
        logic [N-1:0]    en;
        logic [24*N-1:0] hms;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Behavioural model: times as integers, working copy as six decimal digits.
    bit m_edit;
    int m_sel, m_cur;
    int sh[N], sm[N], ss[N];
    bit men[N];
    int wd[6];
    bit m_ring;
    int m_ridx, m_rcnt;
    bit m_snz;
    int m_scnt;
    int ch, cm, cs;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic model_reset();
        m_edit = 0; m_sel = 0; m_cur = 0;
        for (int i = 0; i < N; i++) begin sh[i] = 0; sm[i] = 0; ss[i] = 0; men[i] = 0; end
        for (int i = 0; i < 6; i++) wd[i] = 0;
        m_ring = 0; m_ridx = 0; m_rcnt = 0; m_snz = 0; m_scnt = 0;
    endtask

    task automatic model_step();
        bit any, stop;
        int match, mx;
        if (!reset_n) begin model_reset(); return; end
        any  = btn_up | btn_down | btn_left | btn_right | btn_enter_short | btn_enter_long | btn_return;
        stop = m_ring && any;
        match = -1;
        if (tick_1hz)
            for (int i = N - 1; i >= 0; i--)
                if (men[i] && sh[i] == ch && sm[i] == cm && ss[i] == cs) match = i;
        // ring behaviour (uses enables/slots as they were before this edge)
        if (stop) begin
            m_ring = 0;
`ifdef ALARM_SNOOZE_EN
            m_snz = 1; m_scnt = SNZ;
`endif
        end else if (tick_1hz && !m_ring && match >= 0) begin
            m_ring = 1; m_ridx = match; m_rcnt = RING; m_snz = 0;
        end else if (tick_1hz && m_ring) begin
            m_rcnt--;
            if (m_rcnt == 0) m_ring = 0;
        end else if (m_snz && !men[m_ridx]) begin
            m_snz = 0;
        end else if (m_snz && tick_1hz) begin
            m_scnt--;
            if (m_scnt == 0) begin m_ring = 1; m_rcnt = RING; m_snz = 0; end
        end
        // user interface
        if (m_edit && !active) begin
            m_edit = 0;
        end else if (active && !stop) begin
            if (btn_return) begin
                m_edit = 0;
            end else if (btn_enter_short || btn_enter_long) begin
                if (m_edit) begin
                    if (btn_enter_short) begin
                        ss[m_sel] = wd[1] * 10 + wd[0];
                        sm[m_sel] = wd[3] * 10 + wd[2];
                        sh[m_sel] = wd[5] * 10 + wd[4];
                        men[m_sel] = 1;
                        m_edit = 0;
                    end
                end else if (btn_enter_long) begin
                    wd[0] = ss[m_sel] % 10; wd[1] = ss[m_sel] / 10;
                    wd[2] = sm[m_sel] % 10; wd[3] = sm[m_sel] / 10;
                    wd[4] = sh[m_sel] % 10; wd[5] = sh[m_sel] / 10;
                    m_cur = 0; m_edit = 1;
                end
            end else if (btn_left || btn_right) begin
                if (m_edit) m_cur = btn_left ? (m_cur + 1) % 6 : (m_cur + 5) % 6;
                else        m_sel = btn_left ? (m_sel + N - 1) % N : (m_sel + 1) % N;
            end else if (btn_up || btn_down) begin
                if (m_edit) begin
                    case (m_cur)
                        0, 2:    mx = 9;
                        1, 3:    mx = 5;
                        4:       mx = (wd[5] == 2) ? 3 : 9;
                        default: mx = 2;
                    endcase
                    wd[m_cur] = btn_up ? (wd[m_cur] + 1) % (mx + 1) : (wd[m_cur] + mx) % (mx + 1);
                    if (wd[5] == 2 && wd[4] > 3) wd[4] = 3;
                end else if (btn_up) begin
                    men[m_sel] = !men[m_sel];
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int d[6];
        if (m_edit) begin
            for (int i = 0; i < 6; i++) d[i] = wd[i];
        end else begin
            d[0] = ss[m_sel] % 10; d[1] = ss[m_sel] / 10;
            d[2] = sm[m_sel] % 10; d[3] = sm[m_sel] / 10;
            d[4] = sh[m_sel] % 10; d[5] = sh[m_sel] / 10;
        end
        e.disp     = {4'(d[5]), 4'(d[4]), 4'hA, 4'(d[3]), 4'(d[2]), 4'hA, 4'(d[1]), 4'(d[0])};
        e.point    = men[m_sel] ? 8'hFE : 8'hFF;
        e.is_shine = m_edit;
        e.shine    = m_edit ? 8'(1 << (m_cur + m_cur / 2)) : 8'h00;
        e.ring     = m_ring;
        e.ridx     = 3'(m_ridx);
        for (int i = 0; i < N; i++) begin
            e.en[i] = men[i];
            e.hms[24*i +: 24] = {bcd(sh[i]), bcd(sm[i]), bcd(ss[i])};
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare DUT outputs against every queued expectation.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("disp_digits", 72'(disp_digits), 72'(e.disp));
            check("point",       72'(point),       72'(e.point));
            check("which_shine", 72'(which_shine), 72'(e.shine));
            check("is_shine",    72'(is_shine),    72'(e.is_shine));
            check("alarm_ring",  72'(alarm_ring),  72'(e.ring));
            check("ring_idx",    72'(ring_idx),    72'(e.ridx));
            check("alarm_en",    72'(alarm_en),    72'(e.en));
            check("alarm_hms",   72'(alarm_hms),   72'(e.hms));
        end
    end

    task automatic clear_pulses();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_enter_short = 0; btn_enter_long = 0; btn_return = 0; tick_1hz = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        push_exp();
        clear_pulses();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        ch = h; cm = m; cs = s;
        cur_hour = bcd(h); cur_min = bcd(m); cur_sec = bcd(s);
    endtask

    task automatic press(input int b);
        case (b)
            B_UP:    btn_up = 1;
            B_DOWN:  btn_down = 1;
            B_LEFT:  btn_left = 1;
            B_RIGHT: btn_right = 1;
            B_SHORT: btn_enter_short = 1;
            B_LONG:  btn_enter_long = 1;
            default: btn_return = 1;
        endcase
        step();
    endtask

    task automatic do_tick(input int h, input int m, input int s);
        set_time(h, m, s);
        tick_1hz = 1;
        step();
    endtask

    initial begin
        int k;
        set_time(0, 0, 0);
        // reset and selection wrap
        reset_n = 0; step(); step();
        reset_n = 1; active = 1; step();
        press(B_RIGHT); press(B_RIGHT); press(B_RIGHT); press(B_LEFT); press(B_LEFT);
        // edit slot 1 to 23:59:58 and commit
        press(B_LONG);
        press(B_DOWN); press(B_DOWN);
        press(B_LEFT); press(B_DOWN);
        press(B_LEFT); press(B_DOWN);
        press(B_LEFT); press(B_DOWN);
        press(B_LEFT); press(B_DOWN);
        press(B_LEFT); press(B_UP); press(B_UP);
        press(B_SHORT);
        // hour tens wrap, hour units limited at tens=2, then discard
        press(B_LONG); press(B_RIGHT);
        press(B_UP); press(B_UP); press(B_UP);
        press(B_RIGHT); press(B_UP); press(B_DOWN);
        press(B_RET);
        // slot 0 = 12:00:00
        press(B_LEFT); press(B_LONG);
        press(B_RIGHT); press(B_UP);
        press(B_RIGHT); press(B_UP); press(B_UP);
        press(B_SHORT);
        // ring and timeout
        do_tick(12, 0, 0);
        for (int i = 0; i < RING + 2; i++) begin do_tick(12, 0, 1); step(); end
        // ring stopped by a press that must not toggle the enable
        do_tick(12, 0, 0); step(); press(B_UP); step();
        // stop then wait out a possible snooze
        do_tick(12, 0, 0); press(B_DOWN);
        for (int i = 0; i < SNZ + 2; i++) begin step(); do_tick(12, 0, 1); end
        press(B_RET);
        do_tick(12, 0, 1); press(B_UP); step(); press(B_UP);
        for (int i = 0; i < SNZ + 2; i++) do_tick(12, 0, 1);
        // leaving alarm mode mid-edit, then reset mid-edit
        press(B_LONG); press(B_UP); active = 0; step(); active = 1; step();
        press(B_LONG); press(B_LEFT); reset_n = 0; step(); reset_n = 1; step();
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            active          = ($urandom_range(0, 15) != 0);
            btn_up          = ($urandom_range(0, 9) == 0);
            btn_down        = ($urandom_range(0, 9) == 0);
            btn_left        = ($urandom_range(0, 9) == 0);
            btn_right       = ($urandom_range(0, 9) == 0);
            btn_enter_short = ($urandom_range(0, 9) == 0);
            btn_enter_long  = ($urandom_range(0, 7) == 0);
            btn_return      = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    k = int'($urandom_range(0, N - 1));
                    set_time(sh[k], sm[k], ss[k]);
                end else begin
                    set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                             int'($urandom_range(0, 59)));
                end
                tick_1hz = 1;
            end
            reset_n = ($urandom_range(0, 799) != 0);
            step();
        end
        reset_n = 1;
        step();
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
